control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore-style control sequencer for the Phase 2/3 `DataPath`. Fetches, decodes and executes one instruction at a time by driving every datapath control strobe (register-select, bus-out, register-in, memory, ALU opcode) from a state counter and the loaded IR. Sits beside `DataPath` at the CPU top level and replaces the testbench-driven strobe sequences.

## Interface
- No parameters; opcode encodings and the state enum are package constants.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset; asynchronous and active-high. Also shared with `DataPath`.
- `ir`  in  32  IR contents from `DataPath`; `[31:27]` op, `[26:23]` Ra, `[22:19]` Rb, `[18:15]` Rc, `[18:0]` C.
- `con`  in  1  CON FF output from `DataPath`.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout`  out  1 each  register-select and immediate strobes.
- `PCout`, `PCin`, `IncPC`, `IRin`, `MARin`, `MDRin`, `MDRout`  out  1 each.
- `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`, `CONin`, `Out_portIn`  out  1 each.
- `read`, `write`  out  1 each  memory strobes.
- `opcode`  out  5  ALU operation to `DataPath`.
- `run`  out  1  high while executing; low in reset and HALT.

## Operation
- States: RESET_S, T0–T7, HALT. Outputs are a combinational decode of the registered state and `ir[31:27]`. Strobes not listed for a state are 0. `opcode` is 0 unless listed.
- RESET_S is entered asynchronously while `clear` is high and moves to T0 on the first edge after release.
- Fetch, for all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin.
  - T2: MDRout, IRin.
  - T2 always advances to T3. Decode happens in T3 because IR is valid only after the T2 edge.
- R-ALU (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, `opcode`=`ir[31:27]`, Zin.
  - T5: Zlowout, Gra, Rin. Then T0.
- I-ALU (addi, andi, ori): same as R-ALU, except T4 drives Cout instead of Grc/Rout.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, `opcode`=ADD, Zin.
  - T5: Zlowout, Gra, Rin. Then T0.
- ld:
  - T3–T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: read, MDRin.
  - T7: MDRout, Gra, Rin. Then T0.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin, with read=0 so the MDR mux selects the bus.
  - T7: write. Then T0.
- mul:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, `opcode`=MUL, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Then T0.
- out:
  - T3: Gra, Rout, Out_portIn. Then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, `opcode`=ADD, Zin.
  - T6: Zlowout; PCin only if `con`=1. Then T0.
- nop and all unimplemented opcodes (div, neg, not, jr, jal, in, mfhi, mflo): T3 with no strobes, then T0.
- halt: T3 → HALT. HALT holds all strobes 0 and `run`=0 until `clear`.

## Timing
- Every strobe is held for the full cycle of its state. No sub-cycle pulses.
- Cycles per instruction, including the 3-cycle fetch:
  - 4: out, nop.
  - 6: ALU ops, ldi.
  - 7: mul, br.
  - 8: ld, st.
- Reset value of every output is 0, including `opcode`=0 and `run`=0. `run` becomes 1 in T0.
- Memory is assumed single-cycle. `read` is asserted in the same cycle as MDRin.
- `clear` asserted in any state, including mid-`st` or HALT, forces RESET_S immediately. No further strobes follow; in particular, no `write` is issued after a `clear`.
- `write` and `read` are never both 1. Rin is never asserted in the same cycle as write.

## Structure
- Package `cpu_pkg`: 5-bit opcode constants (ld=00000, ldi=00001, st=00010, add=00011 … shl=01011, addi=01100, andi=01101, ori=01110, div=01111, mul=10000, neg=10001, not=10010, br=10011, jr=10100, jal=10101, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011) and the state enum.
- One module, with no sub-module: a state register block plus a combinational output/next-state decode.

## Test plan
- Reset: raise `clear` mid-cycle → all outputs 0 and `run`=0 immediately. Release `clear` → RESET_S, then T0 on the next edge with PCout=MARin=IncPC=Zin=1.
- ldi R2,0x65: `ir`=0x09000065 → R2=0x00000065 after 6 cycles, and the controller is back in T0.
- add R3,R2,R2: `ir`=0x19910000, following the ldi → R3=0x000000CA, with `opcode`=00011 only in T4.
- st 0x90,R3 followed by ld R4,0x90 → mem[0x90]=0xCA and R4=0xCA. `write` is high in st T7 only; `read` is high in ld T1 and T6 only.
- br with `con`=0 → PC unchanged after fetch increment and PCin low in T6. Same branch with `con`=1 and C=5 → PC = old PC+1+5.
- halt → HALT, `run`=0, all strobes 0 for 10 cycles. Separately, raise `clear` during st T6 → RESET_S and `write` is never asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Opcode encodings and controller state enum shared by the control unit and CPU top.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT
   } state_t;

   // Register-register ALU ops occupy one contiguous opcode range.
   function automatic logic is_r_alu(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

   function automatic logic is_i_alu(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   // ld, ldi and st all start by forming Rb + C as an address/value.
   function automatic logic is_addr_calc(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, decode in T3, execute up to T7, then back to T0.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        con,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic        CONin,
   output logic        Out_portIn,
   output logic        read,
   output logic        write,
   output logic [4:0]  opcode,
   output logic        run
);

   state_t     state_reg;
   state_t     state_next;
   logic [4:0] op;

   // Register fields and the immediate are consumed by DataPath, not here.
   logic unused_ir;
   assign unused_ir = ^ir[26:0];

   assign op = ir[31:27];

   always_ff @(posedge clock or posedge clear) begin
      if (clear) state_reg <= RESET_S;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      Gra = 1'b0;   Grb = 1'b0;    Grc = 1'b0;     Rin = 1'b0;
      Rout = 1'b0;  BAout = 1'b0;  Cout = 1'b0;    PCout = 1'b0;
      PCin = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;    MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0;     Zin = 1'b0;
      Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
      CONin = 1'b0; Out_portIn = 1'b0; read = 1'b0; write = 1'b0;
      opcode = 5'd0;
      run = 1'b0;

      case (state_reg)
         RESET_S: state_next = T0;
         T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            state_next = T1;
         end
         T1: begin
            run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
            state_next = T2;
         end
         T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            state_next = T3;
         end
         T3: begin
            run = 1'b1;
            state_next = T0;
            if (is_r_alu(op) || is_i_alu(op)) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = T4;
            end else if (is_addr_calc(op)) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_next = T4;
            end else if (op == OP_MUL) begin
               Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = T4;
            end else if (op == OP_OUT) begin
               Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1;
            end else if (op == OP_BR) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_next = T4;
            end else if (op == OP_HALT) begin
               state_next = HALT;
            end
         end
         T4: begin
            run = 1'b1;
            state_next = T5;
            if (is_r_alu(op)) begin
               Grc = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1;
            end else if (is_i_alu(op)) begin
               Cout = 1'b1; opcode = op; Zin = 1'b1;
            end else if (is_addr_calc(op)) begin
               Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1;
            end else if (op == OP_MUL) begin
               Grb = 1'b1; Rout = 1'b1; opcode = OP_MUL; Zin = 1'b1;
            end else if (op == OP_BR) begin
               PCout = 1'b1; Yin = 1'b1;
            end else begin
               state_next = T0;
            end
         end
         T5: begin
            run = 1'b1;
            state_next = T6;
            if (is_r_alu(op) || is_i_alu(op) || op == OP_LDI) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = T0;
            end else if (op == OP_LD || op == OP_ST) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (op == OP_MUL) begin
               Zlowout = 1'b1; LOin = 1'b1;
            end else if (op == OP_BR) begin
               Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1;
            end else begin
               state_next = T0;
            end
         end
         T6: begin
            run = 1'b1;
            state_next = T0;
            if (op == OP_LD) begin
               read = 1'b1; MDRin = 1'b1; state_next = T7;
            end else if (op == OP_ST) begin
               // read stays low so the MDR input mux takes the bus value.
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_next = T7;
            end else if (op == OP_MUL) begin
               Zhighout = 1'b1; HIin = 1'b1;
            end else if (op == OP_BR) begin
               Zlowout = 1'b1; PCin = con;
            end
         end
         T7: begin
            run = 1'b1;
            state_next = T0;
            if (op == OP_LD) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op == OP_ST) begin
               write = 1'b1;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = RESET_S;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: per-cycle expected strobe vectors queued per instruction and compared at negedge.
module tb_control_unit;

   logic        clk;
   logic        clear;
   logic [31:0] ir;
   logic        con;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, IRin, MARin;
   logic MDRin, MDRout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, CONin, Out_portIn;
   logic read, write, run;
   logic [4:0] opcode;

   control_unit dut (
      .clock(clk), .clear(clear), .ir(ir), .con(con),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .CONin(CONin), .Out_portIn(Out_portIn),
      .read(read), .write(write), .opcode(opcode), .run(run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [29:0] vec;
   assign vec = {run, opcode, write, read, Out_portIn, CONin, LOin, HIin, Zhighout, Zlowout,
                 Zin, Yin, MDRout, MDRin, MARin, IRin, IncPC, PCin, PCout, Cout, BAout,
                 Rout, Rin, Grc, Grb, Gra};

   localparam logic [29:0] GRA = 30'h1,      GRB = 30'h2,      GRC = 30'h4,      RIN = 30'h8;
   localparam logic [29:0] ROUT = 30'h10,    BAOUT = 30'h20,   COUT = 30'h40,    PCOUT = 30'h80;
   localparam logic [29:0] PCIN = 30'h100,   INCPC = 30'h200,  IRIN = 30'h400,   MARIN = 30'h800;
   localparam logic [29:0] MDRIN = 30'h1000, MDROUT = 30'h2000, YIN = 30'h4000,  ZIN = 30'h8000;
   localparam logic [29:0] ZLOW = 30'h10000, ZHIGH = 30'h20000, HIIN = 30'h40000, LOIN = 30'h80000;
   localparam logic [29:0] CONIN = 30'h100000, OUTP = 30'h200000, READ = 30'h400000;
   localparam logic [29:0] WRITE = 30'h800000, RUN = 30'h20000000;

   typedef struct {
      string       tag;
      logic [29:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rw_viol = 0;
   int   write_after_clear = 0;
   logic clr_win = 1'b0;

   task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] opf(input logic [4:0] o);
      return {1'b0, o, 24'h0};
   endfunction

   task automatic push(input string tag, input logic [29:0] e);
      sb.push_back('{tag, e});
   endtask

   // Expected strobe sequence derived from the instruction class.
   task automatic expect_instr(input string nm, input logic [31:0] irv, input logic c);
      logic [4:0] o;
      o = irv[31:27];
      push({nm, "_T0"}, RUN | PCOUT | MARIN | INCPC | ZIN);
      push({nm, "_T1"}, RUN | ZLOW | PCIN | READ | MDRIN);
      push({nm, "_T2"}, RUN | MDROUT | IRIN);
      if ((o >= 5'd3 && o <= 5'd11) || o == 5'd12 || o == 5'd13 || o == 5'd14) begin
         push({nm, "_T3"}, RUN | GRB | ROUT | YIN);
         if (o <= 5'd11) push({nm, "_T4"}, RUN | GRC | ROUT | ZIN | opf(o));
         else            push({nm, "_T4"}, RUN | COUT | ZIN | opf(o));
         push({nm, "_T5"}, RUN | ZLOW | GRA | RIN);
      end else if (o == 5'd0 || o == 5'd1 || o == 5'd2) begin
         push({nm, "_T3"}, RUN | GRB | BAOUT | YIN);
         push({nm, "_T4"}, RUN | COUT | ZIN | opf(5'd3));
         if (o == 5'd1) begin
            push({nm, "_T5"}, RUN | ZLOW | GRA | RIN);
         end else begin
            push({nm, "_T5"}, RUN | ZLOW | MARIN);
            if (o == 5'd0) begin
               push({nm, "_T6"}, RUN | READ | MDRIN);
               push({nm, "_T7"}, RUN | MDROUT | GRA | RIN);
            end else begin
               push({nm, "_T6"}, RUN | GRA | ROUT | MDRIN);
               push({nm, "_T7"}, RUN | WRITE);
            end
         end
      end else if (o == 5'd16) begin
         push({nm, "_T3"}, RUN | GRA | ROUT | YIN);
         push({nm, "_T4"}, RUN | GRB | ROUT | ZIN | opf(5'd16));
         push({nm, "_T5"}, RUN | ZLOW | LOIN);
         push({nm, "_T6"}, RUN | ZHIGH | HIIN);
      end else if (o == 5'd23) begin
         push({nm, "_T3"}, RUN | GRA | ROUT | OUTP);
      end else if (o == 5'd19) begin
         push({nm, "_T3"}, RUN | GRA | ROUT | CONIN);
         push({nm, "_T4"}, RUN | PCOUT | YIN);
         push({nm, "_T5"}, RUN | COUT | ZIN | opf(5'd3));
         push({nm, "_T6"}, RUN | ZLOW | (c ? PCIN : 30'h0));
      end else begin
         push({nm, "_T3"}, RUN);
      end
   endtask

   // Runs one instruction from T0; limit > 0 stops after that many cycles.
   task automatic run_instr(input string nm, input logic [31:0] irv, input logic c,
                            input int limit);
      exp_t e;
      int   n;
      expect_instr(nm, irv, c);
      n = 0;
      while (sb.size() > 0 && (limit == 0 || n < limit)) begin
         @(posedge clk);
         if (n == 0) begin
            #1;
            ir  = irv;
            con = c;
         end
         @(negedge clk);
         e = sb.pop_front();
         check(e.tag, vec, e.exp);
         n++;
      end
      sb.delete();
      $display("instr %s ir=%h con=%0d cycles=%0d", nm, irv, c, n);
   endtask

   always @(negedge clk) begin
      if (read === 1'b1 && write === 1'b1) rw_viol++;
      if (Rin === 1'b1 && write === 1'b1) rw_viol++;
   end

   always @(posedge write) if (clr_win) write_after_clear++;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0;
      ir    = 32'h0;
      con   = 1'b0;
      #12;
      clear = 1'b1;
      #1;
      check("reset_async", vec, 30'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hold", vec, 30'h0);
      clear = 1'b0;
      #1;
      check("reset_release", vec, 30'h0);

      run_instr("ldi",    32'h09000065, 1'b0, 0);
      run_instr("add",    32'h19910000, 1'b0, 0);
      run_instr("st",     32'h11800090, 1'b0, 0);
      run_instr("ld",     32'h02000090, 1'b0, 0);
      run_instr("sub",    32'h21910000, 1'b0, 0);
      run_instr("shl",    32'h59910000, 1'b0, 0);
      run_instr("addi",   32'h61100007, 1'b0, 0);
      run_instr("mul",    32'h81100000, 1'b0, 0);
      run_instr("out",    32'hB9800000, 1'b0, 0);
      run_instr("nop",    32'hD0000000, 1'b0, 0);
      run_instr("div",    32'h78000000, 1'b0, 0);
      run_instr("jal",    32'hA8000000, 1'b0, 0);
      run_instr("br_c0",  32'h98800005, 1'b0, 0);
      run_instr("br_c1",  32'h98800005, 1'b1, 0);
      run_instr("halt",   32'hD8000000, 1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("halt_idle_%0d", i), vec, 30'h0);
      end
      #2;
      clear = 1'b1;
      #1;
      check("halt_clear", vec, 30'h0);
      @(negedge clk);
      clear = 1'b0;

      run_instr("st_clr", 32'h11800090, 1'b0, 7);
      #2;
      clr_win = 1'b1;
      clear   = 1'b1;
      #1;
      check("st_t6_clear", vec, 30'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("st_clear_hold_%0d", i), vec, 30'h0);
      end
      clear = 1'b0;
      run_instr("nop_after_clr", 32'hD0000000, 1'b0, 0);
      clr_win = 1'b0;
      check("no_write_after_clear", 30'(write_after_clear), 30'h0);
      check("rw_exclusive", 30'(rw_viol), 30'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
